// File: rtl/pronoc_pkg.sv
// Shared constants and types for the output-VC credit tracker.
package pronoc_pkg;

  localparam int OVC_V          = 4;
  localparam int OVC_B          = 4;
  localparam int CREDITw        = $clog2(OVC_B + 1);
  localparam int OVC_NF_THR     = 1;
  localparam bit OVC_ALLOC_MODE = 1'b1;

  // Allocation status of one output VC.
  typedef enum logic {
    OVC_FREE  = 1'b0,
    OVC_ALLOC = 1'b1
  } ovc_state_e;

  // Per-VC view handed to the allocators; packed at the router level.
  typedef struct packed {
    logic [CREDITw-1:0] credit;
    logic               full;
    logic               nearly_full;
    logic               empty;
    logic               status;
    logic               available;
    logic               err_underflow;
    logic               err_overflow;
    logic               err_alloc;
  } ovc_info_t;

endpackage

// File: rtl/ovc_credit_tracker_if.sv
// Bundle of allocator-side and link-side signals of one output port tracker.
interface ovc_credit_tracker_if #(
  parameter int V       = pronoc_pkg::OVC_V,
  parameter int CREDITw = pronoc_pkg::CREDITw
);

  logic [V*CREDITw-1:0] credit_init_val_i;
  logic                 flit_sent_i;
  logic [V-1:0]         flit_vc_i;
  logic [V-1:0]         credit_in_i;
  logic [V-1:0]         ovc_allocate_i;
  logic [V-1:0]         ovc_release_i;

  logic [V*CREDITw-1:0] credit_o;
  logic [V-1:0]         full_o;
  logic [V-1:0]         nearly_full_o;
  logic [V-1:0]         empty_o;
  logic [V-1:0]         status_o;
  logic [V-1:0]         available_o;
  logic [V-1:0]         err_underflow_o;
  logic [V-1:0]         err_overflow_o;
  logic [V-1:0]         err_alloc_o;

  // Router / allocator side: drives events, observes state.
  modport master (
    output credit_init_val_i, flit_sent_i, flit_vc_i, credit_in_i,
           ovc_allocate_i, ovc_release_i,
    input  credit_o, full_o, nearly_full_o, empty_o, status_o, available_o,
           err_underflow_o, err_overflow_o, err_alloc_o
  );

  // Tracker side.
  modport slave (
    input  credit_init_val_i, flit_sent_i, flit_vc_i, credit_in_i,
           ovc_allocate_i, ovc_release_i,
    output credit_o, full_o, nearly_full_o, empty_o, status_o, available_o,
           err_underflow_o, err_overflow_o, err_alloc_o
  );

endinterface

// File: rtl/ovc_credit_counter.sv
// Single output VC: credit cap, credit counter, status machine and flags.
module ovc_credit_counter #(
  parameter int B       = pronoc_pkg::OVC_B,
  parameter int CREDITw = pronoc_pkg::CREDITw,
  parameter int NF_THR  = pronoc_pkg::OVC_NF_THR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CREDITw-1:0] init_val,
  input  logic               dec,
  input  logic               inc,
  input  logic               allocate,
  input  logic               free_req,
  output logic [CREDITw-1:0] credit,
  output logic               full,
  output logic               nearly_full,
  output logic               empty,
  output logic               status,
  output logic               err_underflow,
  output logic               err_overflow,
  output logic               err_alloc
);

  import pronoc_pkg::*;

  logic [CREDITw-1:0] cap_reg;
  logic [CREDITw-1:0] credit_reg;
  logic [CREDITw-1:0] cap_init;
  logic               err_underflow_reg;
  logic               err_overflow_reg;
  logic               err_alloc_reg;
  ovc_state_e         state_reg;

  // A neighbour advertising zero credit means "use the default depth".
  assign cap_init = (init_val == '0) ? CREDITw'(B) : init_val;

  // Cap capture during reset, then credit counting with saturation on errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_reg           <= cap_init;
      credit_reg        <= cap_init;
      err_underflow_reg <= 1'b0;
      err_overflow_reg  <= 1'b0;
    end else begin
      case ({dec, inc})
        2'b10: begin
          if (credit_reg == '0) err_underflow_reg <= 1'b1;
          else                  credit_reg        <= credit_reg - 1'b1;
        end
        2'b01: begin
          if (credit_reg == cap_reg) err_overflow_reg <= 1'b1;
          else                       credit_reg       <= credit_reg + 1'b1;
        end
        default: ;  // idle, or a sent flit and a returned credit cancel out
      endcase
    end
  end

  // Status machine; allocate+release while allocated is back-to-back reuse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= OVC_FREE;
      err_alloc_reg <= 1'b0;
    end else begin
      case (state_reg)
        OVC_FREE: begin
          if (allocate)      state_reg     <= OVC_ALLOC;
          else if (free_req) err_alloc_reg <= 1'b1;
        end
        OVC_ALLOC: begin
          if (allocate && !free_req) err_alloc_reg <= 1'b1;
          else if (!allocate && free_req) state_reg <= OVC_FREE;
        end
        default: state_reg <= OVC_FREE;
      endcase
    end
  end

  assign credit        = credit_reg;
  assign full          = (credit_reg == '0);
  assign nearly_full   = (credit_reg <= CREDITw'(NF_THR));
  assign empty         = (credit_reg == cap_reg);
  assign status        = (state_reg == OVC_ALLOC);
  assign err_underflow = err_underflow_reg;
  assign err_overflow  = err_overflow_reg;
  assign err_alloc     = err_alloc_reg;

endmodule

// File: rtl/ovc_credit_tracker.sv
// Output-port credit/status tracker: V independent per-VC counters.
module ovc_credit_tracker #(
  parameter int V              = pronoc_pkg::OVC_V,
  parameter int B              = pronoc_pkg::OVC_B,
  parameter int CREDITw        = pronoc_pkg::CREDITw,
  parameter int NF_THR         = pronoc_pkg::OVC_NF_THR,
  parameter bit OVC_ALLOC_MODE = pronoc_pkg::OVC_ALLOC_MODE
) (
  input  logic                 clk,
  input  logic                 reset,
  ovc_credit_tracker_if.slave  bus
);

  import pronoc_pkg::*;

  logic [V-1:0] dec;
  logic [V-1:0] full;
  logic [V-1:0] nearly_full;

  // Each set bit of the VC vector is a decrement on that VC.
  assign dec = {V{bus.flit_sent_i}} & bus.flit_vc_i;

  generate
    for (genvar gi = 0; gi < V; gi++) begin : g_ovc
      ovc_credit_counter #(
        .B       (B),
        .CREDITw (CREDITw),
        .NF_THR  (NF_THR)
      ) u_cnt (
        .clk           (clk),
        .reset         (reset),
        .init_val      (bus.credit_init_val_i[gi*CREDITw +: CREDITw]),
        .dec           (dec[gi]),
        .inc           (bus.credit_in_i[gi]),
        .allocate      (bus.ovc_allocate_i[gi]),
        .free_req      (bus.ovc_release_i[gi]),
        .credit        (bus.credit_o[gi*CREDITw +: CREDITw]),
        .full          (full[gi]),
        .nearly_full   (nearly_full[gi]),
        .empty         (bus.empty_o[gi]),
        .status        (bus.status_o[gi]),
        .err_underflow (bus.err_underflow_o[gi]),
        .err_overflow  (bus.err_overflow_o[gi]),
        .err_alloc     (bus.err_alloc_o[gi])
      );

      // Mode 1 grants while any credit remains; mode 0 keeps a reserve.
      assign bus.available_o[gi] = ~bus.status_o[gi] &
                                   (OVC_ALLOC_MODE ? ~full[gi] : ~nearly_full[gi]);
    end
  endgenerate

  assign bus.full_o        = full;
  assign bus.nearly_full_o = nearly_full;

endmodule

// File: tb/tb_ovc_credit_tracker.sv
// Bench for ovc_credit_tracker: vector table plus scoreboard, both alloc modes.
module tb_ovc_credit_tracker;

  localparam int V  = 4;
  localparam int CW = 3;

  typedef struct {
    bit           rst;
    logic [11:0]  init;
    bit           sent;
    logic [3:0]   vc, cin, al, rl;
    logic [11:0]  cred;
    logic [3:0]   st, eu, eo, ea;
  } vec_t;

  typedef struct packed {
    logic [11:0] cred;
    logic [3:0]  full, nf, empty, status, avail1, avail0, eu, eo, ea;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ovc_credit_tracker_if #(.V(V), .CREDITw(CW)) bus1 ();
  ovc_credit_tracker_if #(.V(V), .CREDITw(CW)) bus0 ();

  ovc_credit_tracker #(.V(V), .B(4), .CREDITw(CW), .NF_THR(1), .OVC_ALLOC_MODE(1'b1))
    dut_m1 (.clk(clk), .reset(reset), .bus(bus1));
  ovc_credit_tracker #(.V(V), .B(4), .CREDITw(CW), .NF_THR(1), .OVC_ALLOC_MODE(1'b0))
    dut_m0 (.clk(clk), .reset(reset), .bus(bus0));

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic [2:0] cap_m [V];
  vec_t vecs[$];

  always @(posedge clk)
    if (reset === 1'b0 && bus1.flit_sent_i === 1'b1)
      assert ($onehot(bus1.flit_vc_i)) else $error("illegal multi-hot flit_vc_i");

  function automatic logic [11:0] cr(int c3, int c2, int c1, int c0);
    return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endfunction

  function automatic vec_t mk(bit rst, logic [11:0] init, bit sent, logic [3:0] vc,
                              logic [3:0] cin, logic [3:0] al, logic [3:0] rl,
                              logic [11:0] cred, logic [3:0] st, logic [3:0] eu,
                              logic [3:0] eo, logic [3:0] ea);
    vec_t v;
    v.rst = rst; v.init = init; v.sent = sent; v.vc = vc; v.cin = cin;
    v.al = al; v.rl = rl; v.cred = cred; v.st = st; v.eu = eu; v.eo = eo; v.ea = ea;
    return v;
  endfunction

  // Flags follow directly from the expected credits and captured caps.
  function automatic exp_t expect_of(vec_t v);
    exp_t e;
    logic [2:0] c;
    e.cred = v.cred; e.status = v.st; e.eu = v.eu; e.eo = v.eo; e.ea = v.ea;
    for (int i = 0; i < V; i++) begin
      c           = v.cred[i*3 +: 3];
      e.full[i]   = (c == 3'd0);
      e.nf[i]     = (c <= 3'd1);
      e.empty[i]  = (c == cap_m[i]);
      e.avail1[i] = ~v.st[i] & ~e.full[i];
      e.avail0[i] = ~v.st[i] & ~e.nf[i];
    end
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t a;
    a.cred = bus1.credit_o; a.full = bus1.full_o; a.nf = bus1.nearly_full_o;
    a.empty = bus1.empty_o; a.status = bus1.status_o; a.avail1 = bus1.available_o;
    a.avail0 = bus0.available_o; a.eu = bus1.err_underflow_o;
    a.eo = bus1.err_overflow_o; a.ea = bus1.err_alloc_o;
    return a;
  endfunction

  task automatic drive(vec_t v);
    reset = v.rst;
    bus1.credit_init_val_i = v.init; bus0.credit_init_val_i = v.init;
    bus1.flit_sent_i = v.sent;       bus0.flit_sent_i = v.sent;
    bus1.flit_vc_i = v.vc;           bus0.flit_vc_i = v.vc;
    bus1.credit_in_i = v.cin;        bus0.credit_in_i = v.cin;
    bus1.ovc_allocate_i = v.al;      bus0.ovc_allocate_i = v.al;
    bus1.ovc_release_i = v.rl;       bus0.ovc_release_i = v.rl;
  endtask

  task automatic run(vec_t v);
    exp_t e, a;
    @(negedge clk);
    drive(v);
    if (v.rst)
      for (int i = 0; i < V; i++)
        cap_m[i] = (v.init[i*3 +: 3] == 3'd0) ? 3'd4 : v.init[i*3 +: 3];
    sb.push_back(expect_of(v));
    @(posedge clk);
    #1;
    a = sample();
    e = sb.pop_front();
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL vec%0d: got cred=%h full=%b nf=%b empty=%b st=%b av1=%b av0=%b eu=%b eo=%b ea=%b | want cred=%h full=%b nf=%b empty=%b st=%b av1=%b av0=%b eu=%b eo=%b ea=%b",
               n_vec, a.cred, a.full, a.nf, a.empty, a.status, a.avail1, a.avail0, a.eu, a.eo, a.ea,
               e.cred, e.full, e.nf, e.empty, e.status, e.avail1, e.avail0, e.eu, e.eo, e.ea);
    end else begin
      $display("vec%0d rst=%0d sent=%0d vc=%b cin=%b al=%b rl=%b -> cred=%h st=%b av1=%b av0=%b eu=%b eo=%b ea=%b",
               n_vec, v.rst, v.sent, v.vc, v.cin, v.al, v.rl, a.cred, a.status, a.avail1, a.avail0, a.eu, a.eo, a.ea);
    end
  endtask

  localparam logic [11:0] INIT0 = {3'd0, 3'd3, 3'd2, 3'd4};
  localparam logic [11:0] INIT1 = {3'd7, 3'd0, 3'd5, 3'd3};

  initial begin
    reset = 1'b1;
    drive(mk(1, INIT0, 0, 4'b0, 4'b0, 4'b0, 4'b0, 12'd0, 4'b0, 4'b0, 4'b0, 4'b0));

    //          rst init  sent vc       cin      alloc    release  credit         st       eu       eo       ea
    vecs.push_back(mk(1, INIT0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, cr(4,3,2,4), 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    vecs.push_back(mk(1, INIT0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, cr(4,3,2,4), 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    vecs.push_back(mk(0, INIT0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, cr(4,3,2,4), 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    // drain VC0
    vecs.push_back(mk(0, INIT0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, cr(4,3,2,3), 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    vecs.push_back(mk(0, INIT0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, cr(4,3,2,2), 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    vecs.push_back(mk(0, INIT0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, cr(4,3,2,1), 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    vecs.push_back(mk(0, INIT0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, cr(4,3,2,0), 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    vecs.push_back(mk(0, INIT0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, cr(4,3,2,0), 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    // VC1: send and return together, then overflow at cap
    vecs.push_back(mk(0, INIT0, 1, 4'b0010, 4'b0010, 4'b0000, 4'b0000, cr(4,3,2,0), 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    vecs.push_back(mk(0, INIT0, 0, 4'b0000, 4'b0010, 4'b0000, 4'b0000, cr(4,3,2,0), 4'b0000, 4'b0000, 4'b0010, 4'b0000));
    vecs.push_back(mk(0, INIT0, 1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, cr(4,3,1,0), 4'b0000, 4'b0000, 4'b0010, 4'b0000));
    vecs.push_back(mk(0, INIT0, 0, 4'b0000, 4'b0010, 4'b0000, 4'b0000, cr(4,3,2,0), 4'b0000, 4'b0000, 4'b0010, 4'b0000));
    // VC2: drain to zero, underflow, then return
    vecs.push_back(mk(0, INIT0, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, cr(4,2,2,0), 4'b0000, 4'b0000, 4'b0010, 4'b0000));
    vecs.push_back(mk(0, INIT0, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, cr(4,1,2,0), 4'b0000, 4'b0000, 4'b0010, 4'b0000));
    vecs.push_back(mk(0, INIT0, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, cr(4,0,2,0), 4'b0000, 4'b0000, 4'b0010, 4'b0000));
    vecs.push_back(mk(0, INIT0, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, cr(4,0,2,0), 4'b0000, 4'b0100, 4'b0010, 4'b0000));
    vecs.push_back(mk(0, INIT0, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, cr(4,1,2,0), 4'b0000, 4'b0100, 4'b0010, 4'b0000));
    // VC3 status: allocate, reuse, release, spurious release
    vecs.push_back(mk(0, INIT0, 0, 4'b0000, 4'b0000, 4'b1000, 4'b0000, cr(4,1,2,0), 4'b1000, 4'b0100, 4'b0010, 4'b0000));
    vecs.push_back(mk(0, INIT0, 0, 4'b0000, 4'b0000, 4'b1000, 4'b1000, cr(4,1,2,0), 4'b1000, 4'b0100, 4'b0010, 4'b0000));
    vecs.push_back(mk(0, INIT0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, cr(4,1,2,0), 4'b0000, 4'b0100, 4'b0010, 4'b0000));
    vecs.push_back(mk(0, INIT0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, cr(4,1,2,0), 4'b0000, 4'b0100, 4'b0010, 4'b1000));
    // VC2: double allocate
    vecs.push_back(mk(0, INIT0, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, cr(4,1,2,0), 4'b0100, 4'b0100, 4'b0010, 4'b1000));
    vecs.push_back(mk(0, INIT0, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, cr(4,1,2,0), 4'b0100, 4'b0100, 4'b0010, 4'b1100));
    // cross-VC events in one cycle; VC0 at credit 1 separates the two modes
    vecs.push_back(mk(0, INIT0, 1, 4'b0100, 4'b0001, 4'b0000, 4'b0000, cr(4,0,2,1), 4'b0100, 4'b0100, 4'b0010, 4'b1100));
    vecs.push_back(mk(0, INIT0, 1, 4'b0001, 4'b1000, 4'b0000, 4'b0000, cr(4,0,2,0), 4'b0100, 4'b0100, 4'b1010, 4'b1100));
    // reset beats simultaneous traffic; second reset cycle captures new caps
    vecs.push_back(mk(1, INIT0, 1, 4'b0001, 4'b1111, 4'b1111, 4'b0000, cr(4,3,2,4), 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    vecs.push_back(mk(1, INIT1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, cr(7,4,5,3), 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    vecs.push_back(mk(0, INIT0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, cr(7,4,5,3), 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    vecs.push_back(mk(0, INIT0, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, cr(7,4,5,3), 4'b0000, 4'b0000, 4'b0001, 4'b0000));
    vecs.push_back(mk(0, INIT0, 1, 4'b1000, 4'b0100, 4'b0000, 4'b0000, cr(6,4,5,3), 4'b0000, 4'b0000, 4'b0101, 4'b0000));

    foreach (vecs[i]) run(vecs[i]);

    // Sticky errors survive idle cycles with unrelated init activity.
    for (int k = 0; k < 6; k++)
      run(mk(0, 12'(k), 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, cr(6,4,5,3), 4'b0000, 4'b0000, 4'b0101, 4'b0000));

    // Mid-packet reset, then drain VC1 to zero with underflow while it is reallocated.
    run(mk(0, INIT0, 0, 4'b0000, 4'b0000, 4'b0010, 4'b0000, cr(6,4,5,3), 4'b0010, 4'b0000, 4'b0101, 4'b0000));
    run(mk(1, INIT0, 1, 4'b0010, 4'b0000, 4'b0000, 4'b0010, cr(4,3,2,4), 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    run(mk(0, INIT0, 1, 4'b0010, 4'b0000, 4'b0010, 4'b0000, cr(4,3,1,4), 4'b0010, 4'b0000, 4'b0000, 4'b0000));
    run(mk(0, INIT0, 1, 4'b0010, 4'b0000, 4'b0010, 4'b0010, cr(4,3,0,4), 4'b0010, 4'b0000, 4'b0000, 4'b0000));
    run(mk(0, INIT0, 1, 4'b0010, 4'b0000, 4'b0000, 4'b0010, cr(4,3,0,4), 4'b0000, 4'b0010, 4'b0000, 4'b0000));
    run(mk(0, INIT0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, cr(4,3,0,4), 4'b0000, 4'b0010, 4'b0000, 4'b0000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
